mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-requester arbiter that shares the single RAM port (Addr/Cs/We/Wdata/Rdata/Ack) between requester 0 and requester 1. Requester 0 is the core; requester 1 is the loader/debug port. The block sits between the requesters and the RAM, grants one transaction at a time with round-robin fairness, and registers the memory-side request. It also bounds every transaction with a timeout that reports an error back to the requester.

Parameters:
ADDR_W, 16, address width (matches $clog2 of RAM capacity)
DATA_W, 32, data width (8 * word size in bytes)
TIMEOUT, 64, max Mem_cs-high cycles without Mem_ack before abort; 0 disables timeout

Ports:
Clk  in  1  clock, all logic on rising edge
Rst  in  1  reset, synchronous, active-high
R0_addr  in  ADDR_W  requester 0 address
R0_cs  in  1  requester 0 request, held until R0_ack or R0_err
R0_we  in  1  requester 0 write enable
R0_wdata  in  DATA_W  requester 0 write data
R0_rdata  out  DATA_W  requester 0 read data, valid with R0_ack
R0_ack  out  1  requester 0 completion pulse
R0_err  out  1  requester 0 timeout pulse
R1_addr, R1_cs, R1_we, R1_wdata, R1_rdata, R1_ack, R1_err  same widths and meanings for requester 1
Mem_addr  out  ADDR_W  RAM address, registered
Mem_cs  out  1  RAM chip select, registered
Mem_we  out  1  RAM write enable, registered
Mem_wdata  out  DATA_W  RAM write data, registered
Mem_rdata  in  DATA_W  RAM read data
Mem_ack  in  1  RAM completion, one-cycle pulse
Grant  out  1  index of the current or last granted requester
Busy  out  1  high while in BUSY state

Behaviour:
- Reset: state IDLE. Mem_addr, Mem_cs, Mem_we, Mem_wdata = 0. Grant = 0, Busy = 0. Counter = 0. last pointer = 1, so R0 wins the first tie. All Rx_ack, Rx_err, Rx_rdata = 0.
- States: IDLE and BUSY.
- IDLE, no Rx_cs: stay in IDLE.
- IDLE, exactly one Rx_cs high: grant that requester.
- IDLE, both Rx_cs high: grant the requester not equal to last.
- On grant, next edge: capture the granted requester's addr/we/wdata into Mem_*; Mem_cs <= 1; Grant <= index; last <= index; counter <= 0; state <= BUSY.
- Latency: request sampled in cycle N; Mem_cs is high from cycle N+1.
- BUSY: Mem_* outputs hold constant. Requester inputs are ignored, including Rx_cs dropping mid-transaction; the transaction completes regardless.
- Rx_ack = Mem_ack & (Grant == x) & Busy, combinational.
- Rx_rdata = Mem_rdata when Grant == x and Busy, otherwise 0.
- BUSY with Mem_ack = 1: next edge Mem_cs <= 0, state <= IDLE. This gives one mandatory idle cycle between transactions; no back-to-back grants.
- Timeout (TIMEOUT > 0): counter increments each BUSY cycle without Mem_ack. When counter == TIMEOUT-1 and Mem_ack = 0, Rx_err of the granted requester is high that cycle (combinational). Next edge: Mem_cs <= 0, state <= IDLE, counter <= 0.
- Mem_ack and timeout in the same cycle: Mem_ack wins; only Rx_ack is asserted, never Rx_err.
- Mem_ack while IDLE is a spurious ack: ignored, no Rx_ack.
- Rx_ack and Rx_err are never both high. The non-granted requester never sees ack, err or rdata.
- Counter width: $clog2(TIMEOUT+1), saturating is unnecessary.
- Rst mid-transaction: next edge goes to the reset state. No Rx_ack or Rx_err is generated. Mem_cs = 0 the cycle after Rst is sampled.

Test Plan:
- Single read R0: R0_cs=1, addr=0x0010, we=0 in cycle 0 -> Mem_cs=1, Mem_addr=0x0010 in cycle 1; RAM acks in cycle 3 with 0xDEADBEEF -> R0_ack=1, R0_rdata=0xDEADBEEF in cycle 3; Mem_cs=0 in cycle 4; R1_ack stays 0.
- Contention: R0 and R1 both request from reset -> R0 granted first. After its ack, R1 is granted (Mem_cs re-rises 2 cycles after the ack cycle). With both still requesting, grants then alternate R0, R1, R0.
- Write R1: addr=0x0200, wdata=0x12345678, we=1 -> Mem_we=1 and Mem_wdata=0x12345678 are held constant until Mem_ack. Change R1_wdata mid-transaction -> Mem_wdata unchanged.
- Timeout with TIMEOUT=4, no Mem_ack -> R0_err is high in the 4th Mem_cs-high cycle, Mem_cs=0 the next cycle, R0_ack never asserted. Repeat with Mem_ack in that same 4th cycle -> R0_ack=1, R0_err=0.
- Reset mid-transaction: Rst=1 while BUSY -> next cycle Mem_cs=0, Busy=0, Grant=0, no ack/err. Then a simultaneous request -> R0 is granted first.
- Spurious Mem_ack while IDLE -> R0_ack=R1_ack=0 and state stays IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between the core (requester 0) and the
// loader/debug port (requester 1). Grants one transaction at a time with
// round-robin fairness, registers the memory-side request, and aborts any
// transaction that waits too long for Mem_ack.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] R0_addr,
    input  logic              R0_cs,
    input  logic              R0_we,
    input  logic [DATA_W-1:0] R0_wdata,
    output logic [DATA_W-1:0] R0_rdata,
    output logic              R0_ack,
    output logic              R0_err,
    input  logic [ADDR_W-1:0] R1_addr,
    input  logic              R1_cs,
    input  logic              R1_we,
    input  logic [DATA_W-1:0] R1_wdata,
    output logic [DATA_W-1:0] R1_rdata,
    output logic              R1_ack,
    output logic              R1_err,
    output logic [ADDR_W-1:0] Mem_addr,
    output logic              Mem_cs,
    output logic              Mem_we,
    output logic [DATA_W-1:0] Mem_wdata,
    input  logic [DATA_W-1:0] Mem_rdata,
    input  logic              Mem_ack,
    output logic              Grant,
    output logic              Busy
);

    // A zero TIMEOUT still needs a one-bit counter so the declarations stay legal.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_cs_q, mem_cs_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                grant_q, grant_d;
    logic                last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                busy;
    logic                timeout_hit;
    logic                pick;

    assign busy = (state_q == BUSY);

    // Abort condition: final allowed cycle reached with no ack; a same-cycle ack wins.
    always_comb begin
        timeout_hit = 1'b0;
        if (TIMEOUT > 0) begin
            timeout_hit = busy && !Mem_ack && (cnt_q == CNT_LAST);
        end
    end

    // Next-state: round-robin grant in IDLE, completion/timeout handling in BUSY.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_cs_d    = mem_cs_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        pick        = 1'b0;

        case (state_q)
            IDLE: begin
                if (R0_cs || R1_cs) begin
                    // On contention take whoever was not served last; otherwise the lone requester.
                    pick        = (R0_cs && R1_cs) ? ~last_q : R1_cs;
                    mem_addr_d  = pick ? R1_addr  : R0_addr;
                    mem_we_d    = pick ? R1_we    : R0_we;
                    mem_wdata_d = pick ? R1_wdata : R0_wdata;
                    mem_cs_d    = 1'b1;
                    grant_d     = pick;
                    last_d      = pick;
                    cnt_d       = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (Mem_ack || timeout_hit) begin
                    mem_cs_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                mem_cs_d = 1'b0;
            end
        endcase
    end

    // State and memory-side request registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_cs_q    <= mem_cs_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
        end
    end

    // Requester-side responses only reach the granted requester while a transaction is live.
    always_comb begin
        R0_ack   = Mem_ack && busy && !grant_q;
        R1_ack   = Mem_ack && busy &&  grant_q;
        R0_err   = timeout_hit && !grant_q;
        R1_err   = timeout_hit &&  grant_q;
        R0_rdata = (busy && !grant_q) ? Mem_rdata : '0;
        R1_rdata = (busy &&  grant_q) ? Mem_rdata : '0;
    end

    assign Mem_addr  = mem_addr_q;
    assign Mem_cs    = mem_cs_q;
    assign Mem_we    = mem_we_q;
    assign Mem_wdata = mem_wdata_q;
    assign Grant     = grant_q;
    assign Busy      = busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus for mem_arbiter with a transaction-level
// reference model checked every cycle, plus literal expectations at key points.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [AW-1:0] R0_addr, R1_addr;
    logic          R0_cs, R0_we, R1_cs, R1_we;
    logic [DW-1:0] R0_wdata, R1_wdata;
    logic [DW-1:0] R0_rdata, R1_rdata;
    logic          R0_ack, R0_err, R1_ack, R1_err;
    logic [AW-1:0] Mem_addr;
    logic          Mem_cs, Mem_we;
    logic [DW-1:0] Mem_wdata;
    logic [DW-1:0] Mem_rdata;
    logic          Mem_ack;
    logic          Grant, Busy;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .Clk(Clk), .Rst(Rst),
        .R0_addr(R0_addr), .R0_cs(R0_cs), .R0_we(R0_we), .R0_wdata(R0_wdata),
        .R0_rdata(R0_rdata), .R0_ack(R0_ack), .R0_err(R0_err),
        .R1_addr(R1_addr), .R1_cs(R1_cs), .R1_we(R1_we), .R1_wdata(R1_wdata),
        .R1_rdata(R1_rdata), .R1_ack(R1_ack), .R1_err(R1_err),
        .Mem_addr(Mem_addr), .Mem_cs(Mem_cs), .Mem_we(Mem_we), .Mem_wdata(Mem_wdata),
        .Mem_rdata(Mem_rdata), .Mem_ack(Mem_ack), .Grant(Grant), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, its owner, how many
    // Mem_cs-high cycles it has lived, and the request it latched.
    bit            m_busy  = 1'b0;
    bit            m_owner = 1'b0;
    bit            m_last  = 1'b1;
    int            m_age   = 0;
    logic [AW-1:0] m_addr  = '0;
    bit            m_we    = 1'b0;
    logic [DW-1:0] m_wdata = '0;

    always @(posedge Clk) begin
        if (Rst) begin
            m_busy = 0; m_owner = 0; m_last = 1; m_age = 0;
            m_addr = '0; m_we = 0; m_wdata = '0;
        end else if (!m_busy) begin
            if (R0_cs || R1_cs) begin
                if (R0_cs && R1_cs) m_owner = !m_last;
                else                m_owner = R1_cs;
                m_last  = m_owner;
                m_addr  = m_owner ? R1_addr  : R0_addr;
                m_we    = m_owner ? R1_we    : R0_we;
                m_wdata = m_owner ? R1_wdata : R0_wdata;
                m_busy  = 1;
                m_age   = 1;
            end
        end else if (Mem_ack || (TO > 0 && m_age == TO)) begin
            m_busy = 0;
        end else begin
            m_age++;
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge Clk) begin
        if (chk_en) begin
            bit done_ok, aborted;
            done_ok = m_busy && Mem_ack;
            aborted = m_busy && !Mem_ack && (TO > 0) && (m_age == TO);
            check("Busy",      Busy,      m_busy);
            check("Mem_cs",    Mem_cs,    m_busy);
            check("Grant",     Grant,     m_owner);
            check("Mem_addr",  Mem_addr,  m_addr);
            check("Mem_we",    Mem_we,    m_we);
            check("Mem_wdata", Mem_wdata, m_wdata);
            check("R0_ack",    R0_ack,    done_ok && !m_owner);
            check("R1_ack",    R1_ack,    done_ok &&  m_owner);
            check("R0_err",    R0_err,    aborted && !m_owner);
            check("R1_err",    R1_err,    aborted &&  m_owner);
            check("R0_rdata",  R0_rdata,  (m_busy && !m_owner) ? Mem_rdata : '0);
            check("R1_rdata",  R1_rdata,  (m_busy &&  m_owner) ? Mem_rdata : '0);
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic mid();
        @(negedge Clk);
        #1;
    endtask

    task automatic reset_dut();
        Rst = 1'b1;
        cyc();
        Rst = 1'b0;
    endtask

    logic [AW-1:0] c_addr [4];
    bit            c_grant [4];

    initial begin
        Rst = 1'b1;
        R0_addr = '0; R0_cs = 0; R0_we = 0; R0_wdata = '0;
        R1_addr = '0; R1_cs = 0; R1_we = 0; R1_wdata = '0;
        Mem_rdata = '0; Mem_ack = 0;
        cyc(); cyc();
        Rst = 1'b0;
        chk_en = 1'b1;
        mid();
        check("reset Busy",   Busy,   0);
        check("reset Mem_cs", Mem_cs, 0);
        check("reset Grant",  Grant,  0);

        // Single read from R0
        R0_cs = 1; R0_addr = 16'h0010; R0_we = 0;
        cyc(); mid();
        check("rd Mem_cs",   Mem_cs,   1);
        check("rd Mem_addr", Mem_addr, 32'h0010);
        cyc();
        cyc(); Mem_ack = 1; Mem_rdata = 32'hDEADBEEF; mid();
        check("rd R0_ack",   R0_ack,   1);
        check("rd R0_rdata", R0_rdata, 32'hDEADBEEF);
        check("rd R1_ack",   R1_ack,   0);
        cyc(); Mem_ack = 0; Mem_rdata = '0; R0_cs = 0; mid();
        check("rd Mem_cs low", Mem_cs, 0);
        cyc();

        // Contention from reset: R0 first, then alternate
        reset_dut();
        R0_cs = 1; R0_addr = 16'h0100; R1_cs = 1; R1_addr = 16'h0101;
        c_grant = '{0, 1, 0, 1};
        c_addr  = '{16'h0100, 16'h0101, 16'h0100, 16'h0101};
        for (int k = 0; k < 4; k++) begin
            cyc(); mid();
            check("rr Grant",    Grant,    c_grant[k]);
            check("rr Mem_addr", Mem_addr, c_addr[k]);
            cyc(); Mem_ack = 1; Mem_rdata = 32'h1000 + k;
            cyc(); Mem_ack = 0; Mem_rdata = '0;
            if (k == 3) begin R0_cs = 0; R1_cs = 0; end
            mid();
            check("rr gap Mem_cs", Mem_cs, 0);
        end
        cyc();

        // Write from R1, inputs change mid-transaction
        R1_cs = 1; R1_addr = 16'h0200; R1_wdata = 32'h12345678; R1_we = 1;
        cyc(); mid();
        check("wr Mem_we",    Mem_we,    1);
        check("wr Mem_wdata", Mem_wdata, 32'h12345678);
        R1_wdata = 32'hFFFFFFFF; R1_addr = 16'h0BAD; R1_cs = 0;
        cyc(); mid();
        check("wr held wdata", Mem_wdata, 32'h12345678);
        check("wr held addr",  Mem_addr,  32'h0200);
        cyc(); Mem_ack = 1; mid();
        check("wr R1_ack", R1_ack, 1);
        cyc(); Mem_ack = 0; R1_we = 0; mid();
        cyc();

        // Timeout on R0, no ack
        R0_cs = 1; R0_addr = 16'h0300; R0_we = 0;
        cyc(); cyc(); cyc(); mid();
        check("to early err", R0_err, 0);
        cyc(); mid();
        check("to R0_err", R0_err, 1);
        check("to R0_ack", R0_ack, 0);
        cyc(); R0_cs = 0; mid();
        check("to Mem_cs low", Mem_cs, 0);
        cyc();

        // Ack in the final allowed cycle beats the timeout
        R0_cs = 1;
        cyc(); cyc(); cyc(); cyc(); Mem_ack = 1; Mem_rdata = 32'h0000CAFE; mid();
        check("to-ack R0_ack", R0_ack, 1);
        check("to-ack R0_err", R0_err, 0);
        cyc(); Mem_ack = 0; Mem_rdata = '0; R0_cs = 0; mid();
        cyc();

        // Reset during an R1 transaction
        R1_cs = 1; R1_addr = 16'h0400;
        cyc(); mid();
        check("rst pre Grant", Grant, 1);
        R1_cs = 0; Rst = 1;
        cyc(); Rst = 0; mid();
        check("rst Mem_cs", Mem_cs, 0);
        check("rst Busy",   Busy,   0);
        check("rst Grant",  Grant,  0);
        R0_cs = 1; R1_cs = 1; R0_addr = 16'h0500; R1_addr = 16'h0501;
        cyc(); mid();
        check("rst tie Grant", Grant, 0);
        cyc(); Mem_ack = 1;
        cyc(); Mem_ack = 0; R0_cs = 0; R1_cs = 0;
        cyc();

        // Spurious ack while idle
        Mem_ack = 1; Mem_rdata = 32'hAAAA5555; mid();
        check("sp R0_ack",   R0_ack,   0);
        check("sp R1_ack",   R1_ack,   0);
        check("sp R0_rdata", R0_rdata, 0);
        cyc(); Mem_ack = 0; Mem_rdata = '0; mid();
        check("sp Busy", Busy, 0);
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
